// File: rtl/load_store_queue_p_if.sv
// Issue / commit / memory / ROB-broadcast bundle for the load/store queue.
// slave = the queue itself, master = issue logic, ROB and memory side.
interface load_store_queue_p_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int ROB_W    = 6,
  parameter int SB_DEPTH = 8
);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_is_ld;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [ROB_W-1:0]  in_rob;
  logic              in_ready;
  logic [1:0]        commit_cnt;
  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ROB_W-1:0]  out_rob;
  logic [CNT_W-1:0]  sb_count;

  modport slave (
    input  flush, in_valid, in_is_ld, in_addr, in_data, in_rob, commit_cnt,
           mem_wr_ready, mem_rd_data,
    output in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_rd_valid,
           mem_rd_addr, out_valid, out_data, out_rob, sb_count
  );

  modport master (
    output flush, in_valid, in_is_ld, in_addr, in_data, in_rob, commit_cnt,
           mem_wr_ready, mem_rd_data,
    input  in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_rd_valid,
           mem_rd_addr, out_valid, out_data, out_rob, sb_count
  );
endinterface

// File: rtl/load_store_queue_p.sv
// Load/store queue: circular store buffer (committed entries at the head,
// speculative entries behind them), youngest-match store-to-load forwarding,
// fixed-latency load pipeline and in-order drain of committed stores.
// The commit boundary is held as a count (r_ncmt) instead of a pointer;
// the first speculative slot is r_head + r_ncmt.
module load_store_queue_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int ROB_W    = 6,
  parameter int SB_DEPTH = 8,
  parameter int LD_LAT   = 3
) (
  input logic clk,
  input logic rst,
  load_store_queue_p_if.slave bus
);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);
  localparam int PTR_W = $clog2(SB_DEPTH);

  logic [SB_DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [SB_DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]                r_head, r_tail;
  logic [CNT_W-1:0]                r_count, r_ncmt;

  logic [LD_LAT-1:0]               r_vld_pipe, r_fwd_pipe;
  logic [LD_LAT-1:0][ROB_W-1:0]    r_rob_pipe;
  logic [LD_LAT-1:0][DATA_W-1:0]   r_fd_pipe;

  logic              w_ready, w_acc, w_st_acc, w_ld_acc, w_drain, w_fwd, w_out_vld;
  logic [DATA_W-1:0] w_fwd_data;
  logic [CNT_W-1:0]  w_nspec, w_k, w_ncmt1, w_count1;
  logic [PTR_W-1:0]  w_head1;

  // ready comes from registered occupancy only, so a same-cycle drain never
  // frees a slot for an issue (no bypass); held low during reset
  assign w_ready  = !rst && (r_count < CNT_W'(SB_DEPTH));
  assign w_acc    = bus.in_valid && w_ready && !bus.flush;
  assign w_st_acc = w_acc && !bus.in_is_ld;
  assign w_ld_acc = w_acc && bus.in_is_ld;
  assign w_drain  = (r_ncmt != '0) && bus.mem_wr_ready;

  // Edge ordering: drain frees head, then commit promotes (clamped to the
  // speculative count), then the accepted store appends, then flush.
  assign w_nspec  = r_count - r_ncmt;
  assign w_k      = (CNT_W'(bus.commit_cnt) > w_nspec) ? w_nspec : CNT_W'(bus.commit_cnt);
  assign w_ncmt1  = r_ncmt - CNT_W'(w_drain) + w_k;
  assign w_count1 = r_count - CNT_W'(w_drain);
  assign w_head1  = r_head + PTR_W'(w_drain);

  // Forwarding search oldest->youngest over occupied slots; later hits
  // overwrite earlier ones so the youngest match wins
  always_comb begin
    w_fwd      = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_addr[r_head + PTR_W'(i)] == bus.in_addr)) begin
        w_fwd      = 1'b1;
        w_fwd_data = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  // Store buffer pointers, counts and entry payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ncmt  <= '0;
    end else begin
      r_head <= w_head1;
      r_ncmt <= w_ncmt1;
      if (w_st_acc) begin
        r_addr[r_tail] <= bus.in_addr;
        r_data[r_tail] <= bus.in_data;
      end
      if (bus.flush) begin
        // speculative entries vanish; tail snaps back to the commit boundary
        r_count <= w_ncmt1;
        r_tail  <= w_head1 + PTR_W'(w_ncmt1);
      end else begin
        r_count <= w_count1 + CNT_W'(w_st_acc);
        r_tail  <= r_tail + PTR_W'(w_st_acc);
      end
    end
  end

  // Load pipeline: fixed LD_LAT stages, never stalls, flush kills all valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_fwd_pipe <= '0;
      r_rob_pipe <= '0;
      r_fd_pipe  <= '0;
    end else if (bus.flush) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_ld_acc;
      r_fwd_pipe[0] <= w_fwd;
      r_rob_pipe[0] <= bus.in_rob;
      r_fd_pipe[0]  <= w_fwd_data;
      for (int i = 1; i < LD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_fwd_pipe[i] <= r_fwd_pipe[i-1];
        r_rob_pipe[i] <= r_rob_pipe[i-1];
        r_fd_pipe[i]  <= r_fd_pipe[i-1];
      end
    end
  end

  // A load reaching the exit in a flush cycle is pre-flush work: suppress it
  assign w_out_vld = r_vld_pipe[LD_LAT-1] && !bus.flush;

  assign bus.in_ready     = w_ready;
  assign bus.sb_count     = r_count;
  assign bus.mem_wr_valid = (r_ncmt != '0);
  assign bus.mem_wr_addr  = (r_ncmt != '0) ? r_addr[r_head] : '0;
  assign bus.mem_wr_data  = (r_ncmt != '0) ? r_data[r_head] : '0;
  assign bus.mem_rd_valid = w_ld_acc && !w_fwd;
  assign bus.mem_rd_addr  = (w_ld_acc && !w_fwd) ? bus.in_addr : '0;
  assign bus.out_valid    = w_out_vld;
  assign bus.out_rob      = w_out_vld ? r_rob_pipe[LD_LAT-1] : '0;
  assign bus.out_data     = !w_out_vld           ? '0 :
                            r_fwd_pipe[LD_LAT-1] ? r_fd_pipe[LD_LAT-1] : bus.mem_rd_data;
endmodule

// File: doc/load_store_queue_p.md
Name: load_store_queue_p

Overview:
- Parametrised next-generation load/store unit: a committed/speculative store buffer with youngest-match store-to-load forwarding, a fixed-latency load pipeline, and in-order draining of retired stores to memory.
- Sits between the reservation-station issue path and data memory.
- Results return to the ROB broadcast path.
- Unlike the previous unit, a flush preserves retired (committed) stores, and the unit applies backpressure when full.

Parameters:
DATA_W, 16, data width
ADDR_W, 16, address width
ROB_W, 6, ROB tag width
SB_DEPTH, 8, store buffer entries (power of two, >=2)
LD_LAT, 3, load pipeline latency in cycles (>=1); equals memory read latency

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of speculative state
in_valid  in  1  issue request
in_is_ld  in  1  1=load, 0=store
in_addr  in  ADDR_W  effective address
in_data  in  DATA_W  store data (ignored for loads)
in_rob  in  ROB_W  ROB tag
in_ready  out  1  unit can accept an issue this cycle
commit_cnt  in  2  stores retired by the ROB this cycle (0..2)
mem_wr_valid  out  1  drain write request
mem_wr_addr  out  ADDR_W  drain address
mem_wr_data  out  DATA_W  drain data
mem_wr_ready  in  1  memory accepts the write
mem_rd_valid  out  1  load read request
mem_rd_addr  out  ADDR_W  read address
mem_rd_data  in  DATA_W  read data, valid exactly LD_LAT cycles after mem_rd_valid
out_valid  out  1  load result valid
out_data  out  DATA_W  load result
out_rob  out  ROB_W  load ROB tag
sb_count  out  clog2(SB_DEPTH+1)  occupied store entries

Behaviour:
- Reset (async, any cycle): pointers and counts go to 0, all entries free, pipeline valids cleared, all outputs 0.
- Store buffer: circular. head = oldest entry, cmt_ptr = first speculative entry, tail = next free entry. Each entry is free, spec, or cmt; order is head..cmt_ptr cmt, then cmt_ptr..tail spec.
- in_ready = (sb_count < SB_DEPTH), from registered state only. Loads also stall while the buffer is full. An issue is accepted when in_valid && in_ready.
- Accepted store: written at tail as spec; tail advances on the next edge.
- commit_cnt = k: the oldest k spec entries become cmt. Commit is clamped to the number of spec entries; over-commit is a bench assertion failure.
- Drain: mem_wr_valid = head entry is cmt; addr/data are taken from the head entry. Handshake mem_wr_valid && mem_wr_ready frees head on that edge. At most one drain per cycle.
- Accepted load, same cycle:
  - Search all non-free entries (spec and cmt, including one draining this cycle) for addr == in_addr.
  - On a match, the youngest match (closest to tail) wins: fwd=1, fwd_data latched, mem_rd_valid=0.
  - Otherwise mem_rd_valid=1, mem_rd_addr=in_addr.
  - Either way, push {valid, rob, fwd, fwd_data} into stage 0 of an LD_LAT-deep shift pipeline.
- Pipeline exit (stage LD_LAT-1): out_valid=valid, out_rob=rob, out_data = fwd ? fwd_data : mem_rd_data. Load latency is exactly LD_LAT cycles from acceptance to out_valid; the pipeline never stalls.
- Flush:
  - All spec entries are freed (tail <= cmt_ptr); cmt entries are kept and continue draining.
  - All pipeline valids are cleared; no out_valid is issued for pre-flush loads, and late mem_rd_data is ignored.
  - Same-cycle in_valid is dropped; mem_rd_valid=0.
- Simultaneous events on the same edge, applied in this order: drain frees head, commit_cnt promotes, accept appends, flush frees remaining spec entries.
- Pointers wrap modulo SB_DEPTH. sb_count = cmt + spec entries and updates by the net change on each edge.
- Full buffer with a drain in the same cycle: in_ready stays 0 for that cycle (no bypass).
- Empty buffer: no search match, mem_wr_valid=0.

Test Plan:
1. Store A=0x0010 D=0x1234 rob 5; load A=0x0010 rob 6 next cycle -> mem_rd_valid=0; 3 cycles later out_valid=1, out_data=0x1234, out_rob=6.
2. Stores to 0x0020 with 0x1111 then 0x2222, then load 0x0020 -> out_data=0x2222 (youngest match); load 0x0030 -> mem_rd_valid=1 addr 0x0030, out_data = memory model value.
3. 8 stores with no commit -> sb_count=8, in_ready=0, further in_valid ignored; commit_cnt=2 then mem_wr_ready=1 -> writes issued to the oldest two addresses in order, in_ready returns 1.
4. 4 stores, commit_cnt=2, then flush with mem_wr_ready=0 -> sb_count=2, mem_wr_valid=1 with oldest store; after 2 ready cycles sb_count=0; in-flight load yields no out_valid.
5. Commit_cnt=2, a drain, an accepted store and flush all in one cycle -> state matches the ordering rule; sb_count = prior cmt+2-1.
6. Assert rst mid-drain and mid-load -> all outputs 0 immediately, sb_count=0, no stale out_valid after release.
